// File: rtl/pipe_seg_elastic.sv
// Elastic pipeline segment: valid/ready payload register with optional skid entry,
// flush with optional payload clearing, and a saturating back-pressure counter.
module pipe_seg_elastic #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned CLEAR_DATA = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] bp_cnt,
  input  logic             bp_cnt_clr
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_e;

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] bp_q, bp_d;
  logic             push, pop;

  assign out_valid = (occ_q != S_EMPTY);
  // Single-entry mode forwards downstream ready; skid mode uses the registered copy.
  assign in_ready  = (DEPTH == 1) ? (!out_valid || out_ready) : rdy_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = main_q;
  assign occ       = occ_q;
  assign bp_cnt    = bp_q;

  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d = S_EMPTY;
      if (CLEAR_DATA != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (occ_q)
        S_EMPTY: begin
          if (push) begin
            occ_d  = S_ONE;
            main_d = in_data;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            // Only reachable in skid mode: single mode cannot accept while stalled.
            occ_d  = S_TWO;
            skid_d = in_data;
          end else if (pop) begin
            occ_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (pop) begin
            occ_d  = S_ONE;
            main_d = skid_q;
          end
        end
        default: occ_d = S_EMPTY;
      endcase
    end
    rdy_d = (occ_d != S_TWO);
  end

  always_comb begin
    bp_d = bp_q;
    if (bp_cnt_clr) begin
      bp_d = '0;
    end else if (out_valid && !out_ready && (bp_q != '1)) begin
      bp_d = bp_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      occ_q  <= S_EMPTY;
      main_q <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b1;
      bp_q   <= '0;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
      rdy_q  <= rdy_d;
      bp_q   <= bp_d;
    end
  end

endmodule
